// File: rtl/bcd_color_encoder.sv
// ---------------------------------------------------------------------------
// bcd_color_encoder
//
// Converts an IN_W-bit unsigned value into DIGITS decimal digits using an
// iterative double-dabble (one input bit per clock), then maps every digit
// to a 12-bit RGB colour code for the display path. Values that do not fit
// in DIGITS digits saturate to all nines and raise o_ovf. Leading zero
// digits can optionally be replaced by BLANK_CODE.
//
// Ports
//   clk         clock, rising edge
//   rst         synchronous reset, active-high
//   i_valid     i_num / i_lz_blank valid
//   o_ready     encoder can accept (high only while idle)
//   i_num       unsigned value to encode
//   i_lz_blank  1 = blank leading zero digits with BLANK_CODE
//   o_valid     o_code / o_ovf valid
//   i_ready     downstream accepts the result
//   o_code      colour codes, MS digit in bits [12*DIGITS-1 -: 12]
//   o_ovf       latched value >= 10**DIGITS, result saturated
//   o_busy      conversion in progress
// ---------------------------------------------------------------------------
module bcd_color_encoder #(
    parameter int          IN_W       = 14,
    parameter int          DIGITS     = 4,
    parameter logic [11:0] BLANK_CODE = 12'h111
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [IN_W-1:0]       i_num,
    input  logic                  i_lz_blank,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [12*DIGITS-1:0]  o_code,
    output logic                  o_ovf,
    output logic                  o_busy
);

    // Only the low DIGITS digits are kept. Double-dabble carries flow
    // strictly upward, so truncating the top never corrupts the kept digits;
    // overflow is instead detected by comparing the input against 10**DIGITS
    // once at accept time.
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(IN_W + 1);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int k = 0; k < n; k++) r = r * 64'd10;
        return r;
    endfunction

    localparam logic [63:0] LIMIT = pow10(DIGITS);

    function automatic logic [11:0] digit_color(input logic [3:0] d);
        case (d)
            4'd0:    return 12'h000;
            4'd1:    return 12'hF00;
            4'd2:    return 12'hF80;
            4'd3:    return 12'hFF0;
            4'd4:    return 12'h0F0;
            4'd5:    return 12'h0FF;
            4'd6:    return 12'h08F;
            4'd7:    return 12'h00F;
            4'd8:    return 12'hF0F;
            4'd9:    return 12'hFFF;
            default: return 12'h000;
        endcase
    endfunction

    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int k = 0; k < DIGITS; k++)
            if (b[4*k +: 4] >= 4'd5) r[4*k +: 4] = b[4*k +: 4] + 4'd3;
        return r;
    endfunction

    function automatic logic [12*DIGITS-1:0] encode(input logic [BCD_W-1:0] b,
                                                    input logic ovf,
                                                    input logic lz);
        logic [12*DIGITS-1:0] r;
        logic                 seen;   // a non-zero digit exists at or above this one
        logic [3:0]           d;
        r    = '0;
        seen = 1'b0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            d = b[4*k +: 4];
            if (d != 4'd0) seen = 1'b1;
            if (ovf)
                r[12*k +: 12] = 12'hFFF;
            else if (lz && !seen && k != 0)
                r[12*k +: 12] = BLANK_CODE;
            else
                r[12*k +: 12] = digit_color(d);
        end
        return r;
    endfunction

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [IN_W-1:0]  val;
    logic [BCD_W-1:0] bcd;
    logic [BCD_W-1:0] bcd_adj;
    logic             lz;
    logic             ovf_pend;

    assign bcd_adj = add3(bcd);

    // Control path and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            o_ready <= 1'b1;
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
            o_code  <= '0;
            o_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        cnt     <= CNT_W'(IN_W);
                        o_ready <= 1'b0;
                        o_busy  <= 1'b1;
                        state   <= CONV;
                    end
                end
                CONV: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        // All bits shifted in; publish on the following edge.
                        o_code  <= encode(bcd, ovf_pend, lz);
                        o_ovf   <= ovf_pend;
                        o_valid <= 1'b1;
                        o_busy  <= 1'b0;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Conversion datapath; contents are don't-care outside CONV.
    always_ff @(posedge clk) begin
        if (state == IDLE && i_valid) begin
            val      <= i_num;
            lz       <= i_lz_blank;
            bcd      <= '0;
            ovf_pend <= (64'(i_num) >= LIMIT);
        end else if (state == CONV && cnt != '0) begin
            bcd <= {bcd_adj[BCD_W-2:0], val[IN_W-1]};
            val <= val << 1;
        end
    end

endmodule

// File: tb/tb_bcd_color_encoder.sv
module tb_bcd_color_encoder;

    localparam int IN_W   = 14;
    localparam int DIGITS = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 i_valid;
    logic                 o_ready;
    logic [IN_W-1:0]      i_num;
    logic                 i_lz_blank;
    logic                 o_valid;
    logic                 i_ready;
    logic [12*DIGITS-1:0] o_code;
    logic                 o_ovf;
    logic                 o_busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    bcd_color_encoder #(.IN_W(IN_W), .DIGITS(DIGITS), .BLANK_CODE(12'h111)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_num(i_num), .i_lz_blank(i_lz_blank), .o_valid(o_valid),
        .i_ready(i_ready), .o_code(o_code), .o_ovf(o_ovf), .o_busy(o_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: decimal digits by division, blanking by magnitude.
    function automatic logic [47:0] model_code(input int n, input bit lz);
        logic [11:0] cmap [10];
        logic [47:0] r;
        int          p;
        cmap = '{12'h000, 12'hF00, 12'hF80, 12'hFF0, 12'h0F0,
                 12'h0FF, 12'h08F, 12'h00F, 12'hF0F, 12'hFFF};
        if (n >= 10000) return 48'hFFFFFFFFFFFF;
        r = '0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            if (lz && i > 0 && n < p) r[12*i +: 12] = 12'h111;
            else                      r[12*i +: 12] = cmap[(n / p) % 10];
            p = p * 10;
        end
        return r;
    endfunction

    // One transaction with i_ready held high.
    task automatic run(input int num, input bit lz, output logic [47:0] code,
                       output bit ovf, output int lat, output int acc_cyc);
        int n;
        n = 0;
        while (!o_ready && n < 100) begin @(posedge clk); #1; n++; end
        i_num = IN_W'(num); i_lz_blank = lz; i_valid = 1'b1;
        @(posedge clk);
        acc_cyc = cyc;
        #1 i_valid = 1'b0;
        lat = 0;
        while (!o_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        code = o_code;
        ovf  = o_ovf;
        @(posedge clk); #1;
    endtask

    typedef struct {
        int          num;
        bit          lz;
        logic [47:0] code;
        bit          ovf;
    } vec_t;

    vec_t        vecs[$];
    logic [47:0] code;
    bit          ovf;
    int          lat, acc, prev_acc, num;
    bit          lz;

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_num = '0; i_lz_blank = 1'b0; i_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_ready", 64'(o_ready), 64'd1);
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_code",  64'(o_code),  64'd0);
        check("rst_ovf",   64'(o_ovf),   64'd0);
        check("rst_busy",  64'(o_busy),  64'd0);

        vecs.push_back('{42,    1'b0, 48'h0000000F0F80, 1'b0});
        vecs.push_back('{42,    1'b1, 48'h1111110F0F80, 1'b0});
        vecs.push_back('{0,     1'b1, 48'h111111111000, 1'b0});
        vecs.push_back('{0,     1'b0, 48'h000000000000, 1'b0});
        vecs.push_back('{9999,  1'b0, 48'hFFFFFFFFFFFF, 1'b0});
        vecs.push_back('{10000, 1'b0, 48'hFFFFFFFFFFFF, 1'b1});
        vecs.push_back('{16383, 1'b1, 48'hFFFFFFFFFFFF, 1'b1});
        vecs.push_back('{1234,  1'b0, 48'hF00F80FF00F0, 1'b0});
        vecs.push_back('{305,   1'b1, 48'h111FF00000FF, 1'b0});
        foreach (vecs[i]) begin
            run(vecs[i].num, vecs[i].lz, code, ovf, lat, acc);
            check($sformatf("vec%0d_code", i), 64'(code), 64'(vecs[i].code));
            check($sformatf("vec%0d_ovf", i),  64'(ovf),  64'(vecs[i].ovf));
            check($sformatf("vec%0d_lat", i),  64'(lat),  64'd15);
        end

        // Downstream stall: result held, new requests ignored.
        i_ready = 1'b0;
        i_num = 14'd1234; i_lz_blank = 1'b0; i_valid = 1'b1;
        @(posedge clk); #1 i_valid = 1'b0;
        lat = 0;
        while (!o_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        check("stall_lat", 64'(lat), 64'd15);
        i_num = 14'd77; i_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("stall_code",  64'(o_code),  64'h0000F00F80FF00F0);
            check("stall_valid", 64'(o_valid), 64'd1);
            check("stall_ready", 64'(o_ready), 64'd0);
        end
        i_valid = 1'b0; i_ready = 1'b1;
        @(posedge clk); #1;
        check("hs_valid", 64'(o_valid), 64'd0);
        check("hs_ready", 64'(o_ready), 64'd1);
        check("hs_busy",  64'(o_busy),  64'd0);

        // Reset in the middle of a conversion.
        i_num = 14'd4321; i_valid = 1'b1;
        @(posedge clk); #1 i_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("conv_busy", 64'(o_busy), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check("abort_valid", 64'(o_valid), 64'd0);
        check("abort_busy",  64'(o_busy),  64'd0);
        check("abort_ready", 64'(o_ready), 64'd1);
        run(7, 1'b0, code, ovf, lat, acc);
        check("after_abort_code", 64'(code), 64'h00000000000F);
        check("after_abort_lat",  64'(lat),  64'd15);

        // Back-to-back random and boundary values against the model.
        prev_acc = -1;
        for (int k = 0; k < 260; k++) begin
            case (k)
                0: num = 9;     1: num = 10;   2: num = 99;   3: num = 100;
                4: num = 999;   5: num = 1000; 6: num = 9999; 7: num = 10000;
                default: num = (k % 3 == 0) ? int'($urandom_range(10500, 0))
                                            : int'($urandom_range(9999, 0));
            endcase
            lz = 1'($urandom);
            run(num, lz, code, ovf, lat, acc);
            check($sformatf("rnd_code n=%0d lz=%0d", num, lz), 64'(code), 64'(model_code(num, lz)));
            check($sformatf("rnd_ovf n=%0d", num), 64'(ovf), 64'(num >= 10000));
            if (prev_acc >= 0) check("accept_gap", 64'(acc - prev_acc), 64'd17);
            prev_acc = acc;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
